// File: rtl/ifetch_controller.sv
// Fetch-stage sequencer: owns the fetch PC, reads 4-word lines from a
// combinational I-cache and queues them toward decode.
module ifetch_controller #(
   parameter int unsigned               DATA_WIDTH    = 32,
   parameter int unsigned               ADDRESS_WIDTH = 32,
   parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = '0,
   parameter int unsigned               QUEUE_DEPTH   = 4,
   parameter int unsigned               MAX_RETRY     = 7
) (
   input  logic                       clk,
   input  logic                       rst,
   output logic                       cache_rd_en,
   output logic                       cache_abort,
   output logic [ADDRESS_WIDTH-1:0]   cache_pc,
   input  logic [4*DATA_WIDTH-1:0]    cache_dout,
   input  logic                       cache_dout_valid,
   input  logic                       redirect_valid,
   input  logic [ADDRESS_WIDTH-1:0]   redirect_pc,
   output logic                       fetch_valid,
   input  logic                       fetch_ready,
   output logic [4*DATA_WIDTH-1:0]    fetch_line,
   output logic [ADDRESS_WIDTH-1:0]   fetch_pc,
   output logic                       fetch_error
);

   localparam int LW = 4 * DATA_WIDTH;
   localparam int AW = ADDRESS_WIDTH;
   localparam int PW = (QUEUE_DEPTH > 1) ? $clog2(QUEUE_DEPTH) : 1;
   localparam int CW = PW + 1;
   localparam int RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [CW-1:0] DEPTH_C  = CW'(QUEUE_DEPTH);
   localparam logic [RW-1:0] RETRY_C  = RW'(MAX_RETRY);
   localparam logic [AW-1:0] LINE_INC = AW'(16);
   localparam logic [AW-1:0] LINE_MSK = ~AW'(15);

   typedef enum logic [1:0] {
      S_FETCH,
      S_HOLD,
      S_FLUSH,
      S_ERROR
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   pc_q, pc_d;
   logic [RW-1:0]   retry_q, retry_d;
   logic [CW-1:0]   count_q, count_d;
   logic [PW-1:0]   wptr_q, wptr_d;
   logic [PW-1:0]   rptr_q, rptr_d;

   logic [AW-1:0]   pc_mem_q   [QUEUE_DEPTH];
   logic [LW-1:0]   line_mem_q [QUEUE_DEPTH];

   logic            rd_en;
   logic            abort;
   logic            push;
   logic            pop;
   logic            flush;
   logic            full;
   logic            head_valid;

   assign head_valid = (count_q != '0);
   assign full       = (count_q == DEPTH_C);
   assign pop        = head_valid & fetch_ready;

   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      retry_d = retry_q;
      rd_en   = 1'b0;
      abort   = 1'b0;
      push    = 1'b0;
      flush   = 1'b0;

      if (redirect_valid) begin
         abort   = 1'b1;
         flush   = 1'b1;
         pc_d    = redirect_pc & LINE_MSK;
         retry_d = '0;
         state_d = S_FLUSH;
      end else begin
         unique case (state_q)
            S_FETCH: begin
               rd_en = ~full;
               if (rd_en && cache_dout_valid) begin
                  push    = 1'b1;
                  pc_d    = pc_q + LINE_INC;
                  retry_d = '0;
               end else if (rd_en) begin
                  if (retry_q == RETRY_C) begin
                     state_d = S_ERROR;
                  end else begin
                     retry_d = retry_q + RW'(1);
                  end
               end
            end
            S_HOLD:  state_d = S_HOLD;
            S_FLUSH: state_d = S_FETCH;
            S_ERROR: state_d = S_ERROR;
         endcase
      end

      if (flush) begin
         count_d = '0;
         wptr_d  = '0;
         rptr_d  = '0;
      end else begin
         count_d = count_q + CW'(push) - CW'(pop);
         wptr_d  = wptr_q + PW'(push);
         rptr_d  = rptr_q + PW'(pop);
      end

      // Park in HOLD once the queue fills; resume as soon as a slot frees.
      if (!redirect_valid) begin
         if (state_q == S_FETCH && state_d == S_FETCH && count_d == DEPTH_C) begin
            state_d = S_HOLD;
         end
         if (state_q == S_HOLD && count_d != DEPTH_C) begin
            state_d = S_FETCH;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_FETCH;
         pc_q    <= RESET_PC;
         retry_q <= '0;
         count_q <= '0;
         wptr_q  <= '0;
         rptr_q  <= '0;
      end else begin
         state_q <= state_d;
         pc_q    <= pc_d;
         retry_q <= retry_d;
         count_q <= count_d;
         wptr_q  <= wptr_d;
         rptr_q  <= rptr_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wptr_q]   <= pc_q;
         line_mem_q[wptr_q] <= cache_dout;
      end
   end

   assign cache_rd_en = rd_en & ~rst;
   assign cache_abort = abort & ~rst;
   assign cache_pc    = pc_q;
   assign fetch_valid = head_valid;
   assign fetch_line  = head_valid ? line_mem_q[rptr_q] : '0;
   assign fetch_pc    = head_valid ? pc_mem_q[rptr_q] : '0;
   assign fetch_error = (state_q == S_ERROR);

endmodule

// File: tb/tb_ifetch_controller.sv
// Scoreboard bench for ifetch_controller; a second instance covers
// PC wrap-around from a high reset address.
module tb_ifetch_controller;

   logic         clk;
   logic         rst;
   logic         dv;
   logic         rv;
   logic         fr;
   logic [31:0]  rpc;

   logic         rd_en, abort, fvalid, ferr;
   logic [31:0]  cpc, fpc;
   logic [127:0] cdout, fline;

   logic         rd_en_w, abort_w, fvalid_w, ferr_w;
   logic [31:0]  cpc_w, fpc_w;
   logic [127:0] cdout_w, fline_w;

   int           n_cmp;
   int           n_bad;
   logic [31:0]  exp_q [$];
   logic [31:0]  nxt;
   logic [31:0]  e;
   logic         exp_rd;

   function automatic logic [127:0] mk(input logic [31:0] a);
      return {a ^ 32'hA5A5_5A5A, a + 32'd1, ~a, a + 32'h1234_5678};
   endfunction

   assign cdout   = mk(cpc);
   assign cdout_w = mk(cpc_w);

   ifetch_controller dut (
      .clk              (clk),
      .rst              (rst),
      .cache_rd_en      (rd_en),
      .cache_abort      (abort),
      .cache_pc         (cpc),
      .cache_dout       (cdout),
      .cache_dout_valid (dv),
      .redirect_valid   (rv),
      .redirect_pc      (rpc),
      .fetch_valid      (fvalid),
      .fetch_ready      (fr),
      .fetch_line       (fline),
      .fetch_pc         (fpc),
      .fetch_error      (ferr)
   );

   ifetch_controller #(.RESET_PC(32'hFFFF_FFF0)) dut_w (
      .clk              (clk),
      .rst              (rst),
      .cache_rd_en      (rd_en_w),
      .cache_abort      (abort_w),
      .cache_pc         (cpc_w),
      .cache_dout       (cdout_w),
      .cache_dout_valid (dv),
      .redirect_valid   (rv),
      .redirect_pc      (rpc),
      .fetch_valid      (fvalid_w),
      .fetch_ready      (fr),
      .fetch_line       (fline_w),
      .fetch_pc         (fpc_w),
      .fetch_error      (ferr_w)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      rv  = 1'b0;
      rpc = '0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_q.delete();
   endtask

   task automatic test_reset();
      @(negedge clk);
      rst = 1'b1;
      fr  = 1'b0;
      dv  = 1'b1;
      rv  = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      n_cmp++;
      if (rd_en !== 1'b0 || abort !== 1'b0 || ferr !== 1'b0) begin
         n_bad++;
         $display("FAIL reset_ctl: rd_en=%b abort=%b err=%b want 0 0 0",
                  rd_en, abort, ferr);
      end
      n_cmp++;
      if (cpc !== 32'h0 || cpc_w !== 32'hFFFF_FFF0) begin
         n_bad++;
         $display("FAIL reset_pc: pc=%h pc_w=%h want 0 fffffff0", cpc, cpc_w);
      end
      n_cmp++;
      if (fvalid !== 1'b0 || fpc !== 32'h0 || fline !== 128'h0) begin
         n_bad++;
         $display("FAIL reset_fifo: v=%b pc=%h line=%h want 0 0 0",
                  fvalid, fpc, fline);
      end
   endtask

   task automatic test_basic();
      fr = 1'b1;
      dv = 1'b1;
      do_reset();
      nxt = 32'h0;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         n_cmp++;
         if (rd_en !== 1'b1 || cpc !== nxt) begin
            n_bad++;
            $display("FAIL basic_rd c=%0d: rd_en=%b pc=%h want 1 %h",
                     c, rd_en, cpc, nxt);
         end
         n_cmp++;
         if (fvalid !== (c > 0)) begin
            n_bad++;
            $display("FAIL basic_valid c=%0d: got %b want %b", c, fvalid, c > 0);
         end
         exp_q.push_back(nxt);
         nxt = nxt + 32'h10;
         if (fvalid && fr) begin
            n_cmp++;
            e = exp_q.pop_front();
            if (fpc !== e || fline !== mk(e)) begin
               n_bad++;
               $display("FAIL basic_pop: pc=%h want %h", fpc, e);
            end
         end
      end
   endtask

   task automatic test_backpressure();
      fr = 1'b0;
      dv = 1'b1;
      do_reset();
      nxt = 32'h0;
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         fr = (c == 6);
         #1;
         exp_rd = (c < 4) || (c == 7);
         n_cmp++;
         if (rd_en !== exp_rd || (exp_rd && cpc !== nxt)) begin
            n_bad++;
            $display("FAIL bp_rd c=%0d: rd_en=%b pc=%h want %b %h",
                     c, rd_en, cpc, exp_rd, nxt);
         end
         if (c >= 1) begin
            n_cmp++;
            if (fvalid !== 1'b1 || fpc !== exp_q[0]) begin
               n_bad++;
               $display("FAIL bp_head c=%0d: v=%b pc=%h want 1 %h",
                        c, fvalid, fpc, exp_q[0]);
            end
         end
         if (exp_rd) begin
            exp_q.push_back(nxt);
            nxt = nxt + 32'h10;
         end
         if (fvalid && fr) begin
            n_cmp++;
            e = exp_q.pop_front();
            if (fpc !== e || fline !== mk(e)) begin
               n_bad++;
               $display("FAIL bp_pop c=%0d: pc=%h want %h", c, fpc, e);
            end
         end
      end
      for (int c = 0; c < 8; c++) begin
         @(negedge clk);
         fr = 1'b1;
         #1;
         if (rd_en) begin
            n_cmp++;
            if (cpc !== nxt) begin
               n_bad++;
               $display("FAIL drain_pc: pc=%h want %h", cpc, nxt);
            end
            exp_q.push_back(nxt);
            nxt = nxt + 32'h10;
         end
         if (fvalid && fr) begin
            n_cmp++;
            if (exp_q.size() == 0) begin
               n_bad++;
               $display("FAIL drain_pop: pc=%h want none", fpc);
            end else begin
               e = exp_q.pop_front();
               if (fpc !== e || fline !== mk(e)) begin
                  n_bad++;
                  $display("FAIL drain_pop: pc=%h want %h", fpc, e);
               end
            end
         end
      end
   endtask

   task automatic test_redirect();
      fr = 1'b0;
      dv = 1'b1;
      do_reset();
      nxt = 32'h0;
      for (int c = 0; c < 13; c++) begin
         if (c > 0) @(negedge clk);
         rv  = (c == 5) || (c == 9) || (c == 10);
         rpc = (c == 5) ? 32'h104 : (c == 9) ? 32'h3F8 : 32'h50C;
         fr  = (c >= 7);
         #1;
         exp_rd = (c < 4) || (c == 7) || (c == 8) || (c == 12);
         n_cmp++;
         if (abort !== rv) begin
            n_bad++;
            $display("FAIL rd_abort c=%0d: got %b want %b", c, abort, rv);
         end
         n_cmp++;
         if (fvalid !== (exp_q.size() != 0)) begin
            n_bad++;
            $display("FAIL rd_valid c=%0d: got %b want %b",
                     c, fvalid, exp_q.size() != 0);
         end
         n_cmp++;
         if (rd_en !== exp_rd || (exp_rd && cpc !== nxt)) begin
            n_bad++;
            $display("FAIL rd_rd c=%0d: rd_en=%b pc=%h want %b %h",
                     c, rd_en, cpc, exp_rd, nxt);
         end
         if (exp_rd) begin
            exp_q.push_back(nxt);
            nxt = nxt + 32'h10;
         end
         if (fvalid && fr && !rv) begin
            n_cmp++;
            e = exp_q.pop_front();
            if (fpc !== e || fline !== mk(e)) begin
               n_bad++;
               $display("FAIL rd_pop c=%0d: pc=%h want %h", c, fpc, e);
            end
         end
         if (rv) begin
            exp_q.delete();
            nxt = rpc & 32'hFFFF_FFF0;
         end
      end
      rv = 1'b0;
   endtask

   task automatic test_retry();
      fr = 1'b1;
      dv = 1'b0;
      do_reset();
      for (int c = 0; c < 10; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         n_cmp++;
         if (rd_en !== (c < 8) || cpc !== 32'h0 || ferr !== (c >= 8)) begin
            n_bad++;
            $display("FAIL retry c=%0d: rd_en=%b pc=%h err=%b want %b 0 %b",
                     c, rd_en, cpc, ferr, c < 8, c >= 8);
         end
      end
      @(negedge clk);
      rv  = 1'b1;
      rpc = 32'h200;
      dv  = 1'b1;
      #1;
      n_cmp++;
      if (abort !== 1'b1 || rd_en !== 1'b0 || ferr !== 1'b1) begin
         n_bad++;
         $display("FAIL err_redir: abort=%b rd_en=%b err=%b want 1 0 1",
                  abort, rd_en, ferr);
      end
      @(negedge clk);
      rv = 1'b0;
      #1;
      n_cmp++;
      if (ferr !== 1'b0 || rd_en !== 1'b0) begin
         n_bad++;
         $display("FAIL err_flush: err=%b rd_en=%b want 0 0", ferr, rd_en);
      end
      nxt = 32'h200;
      for (int k = 0; k < 17; k++) begin
         @(negedge clk);
         dv = (k == 7);
         #1;
         n_cmp++;
         if (rd_en !== (k < 16) || ferr !== (k == 16)) begin
            n_bad++;
            $display("FAIL retry2 k=%0d: rd_en=%b err=%b want %b %b",
                     k, rd_en, ferr, k < 16, k == 16);
         end
         if (k < 16) begin
            n_cmp++;
            if (cpc !== nxt) begin
               n_bad++;
               $display("FAIL retry2_pc k=%0d: pc=%h want %h", k, cpc, nxt);
            end
            if (dv) begin
               exp_q.push_back(nxt);
               nxt = nxt + 32'h10;
            end
         end
         if (fvalid && fr) begin
            n_cmp++;
            e = exp_q.pop_front();
            if (fpc !== e || fline !== mk(e)) begin
               n_bad++;
               $display("FAIL retry2_pop: pc=%h want %h", fpc, e);
            end
         end
      end
      dv = 1'b1;
   endtask

   task automatic test_wrap();
      fr = 1'b1;
      dv = 1'b1;
      do_reset();
      nxt = 32'hFFFF_FFF0;
      for (int c = 0; c < 4; c++) begin
         if (c > 0) @(negedge clk);
         #1;
         n_cmp++;
         if (rd_en_w !== 1'b1 || cpc_w !== nxt || ferr_w !== 1'b0) begin
            n_bad++;
            $display("FAIL wrap_rd c=%0d: rd_en=%b pc=%h err=%b want 1 %h 0",
                     c, rd_en_w, cpc_w, ferr_w, nxt);
         end
         exp_q.push_back(nxt);
         nxt = nxt + 32'h10;
         if (fvalid_w && fr) begin
            n_cmp++;
            e = exp_q.pop_front();
            if (fpc_w !== e || fline_w !== mk(e)) begin
               n_bad++;
               $display("FAIL wrap_pop: pc=%h want %h", fpc_w, e);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      fr = 1'b0;
      dv = 1'b1;
      do_reset();
      nxt = 32'h0;
      for (int c = 0; c < 6; c++) begin
         if (c > 0) @(negedge clk);
         rst = (c == 3) || (c == 4);
         #1;
         exp_rd = (c < 3) || (c == 5);
         n_cmp++;
         if (rd_en !== exp_rd || cpc !== nxt) begin
            n_bad++;
            $display("FAIL mid_rd c=%0d: rd_en=%b pc=%h want %b %h",
                     c, rd_en, cpc, exp_rd, nxt);
         end
         n_cmp++;
         if (fvalid !== (exp_q.size() != 0)) begin
            n_bad++;
            $display("FAIL mid_valid c=%0d: got %b want %b",
                     c, fvalid, exp_q.size() != 0);
         end
         if (exp_rd) begin
            exp_q.push_back(nxt);
            nxt = nxt + 32'h10;
         end
         if (rst) begin
            exp_q.delete();
            nxt = 32'h0;
         end
      end
   endtask

   initial begin
      n_cmp = 0;
      n_bad = 0;
      rst   = 1'b1;
      dv    = 1'b0;
      rv    = 1'b0;
      fr    = 1'b0;
      rpc   = '0;
      test_reset();
      test_basic();
      test_backpressure();
      test_redirect();
      test_retry();
      test_wrap();
      test_reset_mid();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
